// File: rtl/mem_port_arbiter_if.sv
// Memory-port arbiter bus: per-requester lock requests and access fields
// in, one-hot grant and the muxed memory-port signals out.
//
// Signals:
//   req, req_issue_id, release_lock, req_addr, req_wdata, req_wen
//     requester -> arbiter (slot i at [i*W +: W])
//   grant, mem_addr, mem_wdata, mem_wen
//     arbiter -> requesters and memory
interface mem_port_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 6
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*ID_WIDTH-1:0] req_issue_id;
    logic [NUM_REQ-1:0]          release_lock;
    logic [NUM_REQ*30-1:0]       req_addr;
    logic [NUM_REQ*32-1:0]       req_wdata;
    logic [NUM_REQ-1:0]          req_wen;
    logic [NUM_REQ-1:0]          grant;
    logic [29:0]                 mem_addr;
    logic [31:0]                 mem_wdata;
    logic                        mem_wen;

    modport master (
        output req, req_issue_id, release_lock,
        output req_addr, req_wdata, req_wen,
        input  grant, mem_addr, mem_wdata, mem_wen
    );

    modport slave (
        input  req, req_issue_id, release_lock,
        input  req_addr, req_wdata, req_wen,
        output grant, mem_addr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port among NUM_REQ requesters: oldest issue_id
// wins, the lock is held until release/abort, and wait counters stop starvation.
//
// Ports:
//   clk   - clock, all state on posedge
//   rst_n - asynchronous active-low reset
//   bus   - mem_port_arbiter_if slave (requests in, grant + memory port out)
module mem_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 6,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state;
    logic [OW-1:0]     owner;
    logic [7:0]        wait_cnt [NUM_REQ];

    logic [ID_WIDTH-1:0] ids [NUM_REQ];
    logic                any_req;
    logic                starve_hit;
    logic [OW-1:0]       starve_idx;
    logic                age_hit;
    logic [OW-1:0]       age_idx;
    logic [OW-1:0]       winner;
    logic [NUM_REQ-1:0]  gnt;
    logic [29:0]         addr_mux;
    logic [31:0]         wdata_mux;
    logic                wen_mux;

    // a is older than b when b - a is a small positive distance mod 2^W.
    function automatic logic older(
        input logic [ID_WIDTH-1:0] a,
        input logic [ID_WIDTH-1:0] b
    );
        logic [ID_WIDTH-1:0] d;
        d = b - a;
        return (d != '0) && !d[ID_WIDTH-1];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ids[i] = bus.req_issue_id[i*ID_WIDTH +: ID_WIDTH];
        end
    end

    // Winner selection; strict "older" keeps ties on the lower index.
    always_comb begin
        any_req    = |bus.req;
        starve_hit = 1'b0;
        starve_idx = '0;
        age_hit    = 1'b0;
        age_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] && !starve_hit &&
                wait_cnt[i] >= 8'(MAX_WAIT)) begin
                starve_hit = 1'b1;
                starve_idx = OW'(i);
            end
            if (bus.req[i] &&
                (!age_hit || older(ids[i], ids[age_idx]))) begin
                age_hit = 1'b1;
                age_idx = OW'(i);
            end
        end
        winner = starve_hit ? starve_idx : age_idx;
    end

    // Grant is gated by rst_n so outputs are quiet during reset.
    always_comb begin
        gnt = '0;
        if (rst_n) begin
            if (state == LOCKED) begin
                gnt[owner] = bus.req[owner];
            end else if (any_req) begin
                gnt[winner] = 1'b1;
            end
        end
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        wen_mux   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                addr_mux  = addr_mux  | bus.req_addr[i*30 +: 30];
                wdata_mux = wdata_mux | bus.req_wdata[i*32 +: 32];
                wen_mux   = wen_mux   | bus.req_wen[i];
            end
        end
    end

    assign bus.grant     = gnt;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.mem_wen   = wen_mux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= 8'd0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req && !bus.release_lock[winner]) begin
                        state <= LOCKED;
                        owner <= winner;
                    end
                end
                LOCKED: begin
                    if (!bus.req[owner] || bus.release_lock[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req[i] || gnt[i]) begin
                    wait_cnt[i] <= 8'd0;
                end else if (wait_cnt[i] != 8'hFF) begin
                    wait_cnt[i] <= wait_cnt[i] + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random
// traffic, expectations from a behavioural model, checked at negedge.
module tb_mem_port_arbiter;
    localparam int N  = 4;
    localparam int IW = 6;
    localparam int MW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NUM_REQ(N), .ID_WIDTH(IW)) bus ();

    mem_port_arbiter #(
        .NUM_REQ(N), .ID_WIDTH(IW), .MAX_WAIT(MW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [N-1:0] g;
        logic [29:0]  a;
        logic [31:0]  d;
        logic         w;
        int           dg;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    bit m_lock;
    int m_own;
    int m_wait [N];

    function automatic bit is_older(int a, int b);
        int d;
        d = (b - a) & ((1 << IW) - 1);
        return (d != 0) && (d < (1 << (IW - 1)));
    endfunction

    function automatic logic [N*IW-1:0] pack_ids(int a, int b, int c, int e);
        logic [N*IW-1:0] v;
        v[0*IW +: IW] = IW'(a);
        v[1*IW +: IW] = IW'(b);
        v[2*IW +: IW] = IW'(c);
        v[3*IW +: IW] = IW'(e);
        return v;
    endfunction

    // Reference arbitration: a starving requester, else the requester
    // that no other requester is older than (ties to the lower index).
    function automatic int pick(logic [N-1:0] r, logic [N*IW-1:0] ids);
        int idv [N];
        for (int i = 0; i < N; i++) idv[i] = int'(ids[i*IW +: IW]);
        for (int i = 0; i < N; i++)
            if (r[i] && m_wait[i] >= MW) return i;
        for (int i = 0; i < N; i++) begin
            bit ok;
            if (!r[i]) continue;
            ok = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (j == i || !r[j]) continue;
                if (is_older(idv[j], idv[i])) ok = 1'b0;
                if (idv[j] == idv[i] && j < i) ok = 1'b0;
            end
            if (ok) return i;
        end
        return -1;
    endfunction

    task automatic step(
        input bit              rv,
        input logic [N-1:0]    r,
        input logic [N*IW-1:0] ids,
        input logic [N-1:0]    rel,
        input logic [N-1:0]    wen,
        input int              dg
    );
        exp_t e;
        int   w;
        @(posedge clk);
        #1;
        rst_n            = rv;
        bus.req          = r;
        bus.req_issue_id = ids;
        bus.release_lock = rel;
        bus.req_wen      = wen;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*30 +: 30]  = 30'($urandom);
            bus.req_wdata[i*32 +: 32] = $urandom;
        end
        e.g = '0; e.a = '0; e.d = '0; e.w = 1'b0; e.dg = dg;
        if (!rv) begin
            m_lock = 1'b0;
            m_own  = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            w = -1;
            if (m_lock) begin
                if (r[m_own]) w = m_own;
            end else begin
                w = pick(r, ids);
            end
            if (w >= 0) begin
                e.g[w] = 1'b1;
                e.a = bus.req_addr[w*30 +: 30];
                e.d = bus.req_wdata[w*32 +: 32];
                e.w = wen[w];
            end
            for (int i = 0; i < N; i++) begin
                if (!r[i] || e.g[i]) m_wait[i] = 0;
                else if (m_wait[i] < 255) m_wait[i]++;
            end
            if (m_lock) begin
                if (!r[m_own] || rel[m_own]) m_lock = 1'b0;
            end else if (w >= 0 && !rel[w]) begin
                m_lock = 1'b1;
                m_own  = w;
            end
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (bus.grant === e.g) passed++;
            else $display("FAIL grant got=%b exp=%b t=%0t",
                          bus.grant, e.g, $time);
            if (e.dg >= 0) begin
                checks++;
                if (bus.grant === N'(e.dg)) passed++;
                else $display("FAIL directed_grant got=%b exp=%b t=%0t",
                              bus.grant, N'(e.dg), $time);
            end
            checks++;
            if (bus.mem_addr === e.a && bus.mem_wdata === e.d &&
                bus.mem_wen === e.w) passed++;
            else $display("FAIL mem_port got=%h/%h/%b exp=%h/%h/%b t=%0t",
                          bus.mem_addr, bus.mem_wdata, bus.mem_wen,
                          e.a, e.d, e.w, $time);
        end
    end

    initial begin
        logic [N-1:0]    r;
        logic [N-1:0]    rel;
        logic [N*IW-1:0] ids;
        int              base;
        bus.req = '0; bus.req_issue_id = '0; bus.release_lock = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_wen = '0;
        m_lock = 1'b0; m_own = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        repeat (2) @(posedge clk);

        // reset holds every output low even with a request present
        step(0, 4'b0001, pack_ids(5, 0, 0, 0), 4'b0000, 4'b0001, 0);
        // single-cycle access
        step(1, 4'b0001, pack_ids(5, 0, 0, 0), 4'b0001, 4'b0001, 1);
        step(1, 4'b0000, pack_ids(0, 0, 0, 0), 4'b0000, 4'b0000, 0);
        // age order across the id wrap
        step(1, 4'b0110, pack_ids(0, 62, 1, 0), 4'b0110, 4'b0000, 2);
        step(1, 4'b0100, pack_ids(0, 62, 1, 0), 4'b0100, 4'b0000, 4);
        // multi-cycle lock held against an older waiter
        step(1, 4'b1000, pack_ids(1, 0, 0, 3), 4'b0000, 4'b1000, 8);
        step(1, 4'b1001, pack_ids(1, 0, 0, 3), 4'b0000, 4'b1000, 8);
        step(1, 4'b1001, pack_ids(1, 0, 0, 3), 4'b0000, 4'b1000, 8);
        step(1, 4'b1001, pack_ids(1, 0, 0, 3), 4'b1000, 4'b1000, 8);
        step(1, 4'b0001, pack_ids(1, 0, 0, 3), 4'b0001, 4'b0001, 1);
        // abort by the owner
        step(1, 4'b0011, pack_ids(10, 12, 0, 0), 4'b0000, 4'b0011, 1);
        step(1, 4'b0010, pack_ids(10, 12, 0, 0), 4'b0000, 4'b0011, 0);
        step(1, 4'b0010, pack_ids(10, 12, 0, 0), 4'b0010, 4'b0010, 2);
        // starvation override beats age order
        step(1, 4'b1001, pack_ids(10, 11, 12, 20), 4'b1111, 4'b0000, 1);
        step(1, 4'b1010, pack_ids(10, 11, 12, 20), 4'b1111, 4'b0000, 2);
        step(1, 4'b1100, pack_ids(10, 11, 12, 20), 4'b1111, 4'b0000, 4);
        step(1, 4'b1001, pack_ids(10, 11, 12, 20), 4'b1111, 4'b0000, 8);
        step(1, 4'b0000, pack_ids(0, 0, 0, 0), 4'b0000, 4'b0000, 0);
        // reset while locked with a store in flight
        step(1, 4'b0001, pack_ids(7, 0, 0, 0), 4'b0000, 4'b0001, 1);
        step(1, 4'b0001, pack_ids(7, 0, 0, 0), 4'b0000, 4'b0001, 1);
        step(0, 4'b0001, pack_ids(7, 0, 0, 0), 4'b0000, 4'b0001, 0);
        step(1, 4'b0100, pack_ids(0, 0, 9, 0), 4'b0000, 4'b0000, 4);

        // random traffic; ids stay inside a window so age is a total order
        base = 40;
        for (int c = 0; c < 600; c++) begin
            base = (base + int'($urandom_range(0, 2))) & 63;
            for (int i = 0; i < N; i++) begin
                r[i]   = ($urandom_range(0, 3) != 0);
                rel[i] = ($urandom_range(0, 2) == 0);
                ids[i*IW +: IW] = IW'(base + int'($urandom_range(0, 20)));
            end
            step((c % 150) != 149, r, ids, rel, N'($urandom), -1);
        end

        @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between NUM_REQ Mem sub-SICs.
- Each requester raises a lock request tagged with its issue_id. The arbiter grants the port to the oldest requester by modular issue_id age, holds the lock until the owner releases or drops its request, and muxes the owner's address, write data and write enable onto the memory port.
- Per-requester wait counters force a grant to any requester that has waited MAX_WAIT cycles, so no requester starves.

Parameters:
- NUM_REQ, 4, number of Mem sub-SIC requesters (2..8).
- ID_WIDTH, 6, issue_id width; age comparison is modulo 2^ID_WIDTH.
- MAX_WAIT, 15, consecutive ungranted request cycles that trigger a starvation override (1..255).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester lock request.
- req_issue_id  in  NUM_REQ*ID_WIDTH  issue_id of each requester; slot i occupies bits [i*ID_WIDTH +: ID_WIDTH].
- release_lock  in  NUM_REQ  owner releases the lock this cycle; only honoured together with grant.
- req_addr  in  NUM_REQ*30  word address per requester.
- req_wdata  in  NUM_REQ*32  store data per requester.
- req_wen  in  NUM_REQ  store enable per requester.
- grant  out  NUM_REQ  one-hot-or-zero grant (combinational).
- mem_addr  out  30  muxed word address to memory.
- mem_wdata  out  32  muxed store data.
- mem_wen  out  1  req_wen of the granted requester, gated by its grant.

Behaviour:
- State registers:
  - lock_valid (1 bit) and owner (clog2(NUM_REQ) bits).
  - wait_cnt[i]: 8-bit saturating counter per requester.
  - Reset value of all: 0.
- Outputs: grant, mem_addr, mem_wdata and mem_wen are combinational. While rst_n=0 all outputs are 0, because state is 0 and the selected values are zero-gated.
- Age rule: a is older than b iff d = (b - a) mod 2^ID_WIDTH satisfies d != 0 and d[ID_WIDTH-1] = 0. Equal ids tie-break to the lower index.
- IDLE (lock_valid=0), winner selection, in priority order:
  - Starvation: if any requester has req=1 and wait_cnt >= MAX_WAIT, the lowest such index wins.
  - Otherwise the oldest requesting index wins.
  - With no req: grant=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- IDLE, on a grant (zero additional latency):
  - grant[winner]=1 in the same cycle.
  - If release_lock[winner]=1 in that cycle (single-cycle access), stay in IDLE; otherwise next state is lock_valid=1, owner=winner.
- LOCKED (lock_valid=1):
  - grant[owner] = req[owner]; every other grant bit is 0.
  - release_lock[owner]=1 with grant -> lock_valid=0 next cycle.
  - req[owner]=0 (abort/mispredict) -> no grant this cycle, mem_wen=0, lock_valid=0 next cycle.
  - New arbitration happens only in the cycle after either release.
- Mux: mem_addr, mem_wdata and mem_wen come from the granted index; mem_wen = req_wen[g] & grant[g]. release_lock without grant is ignored.
- wait_cnt[i] update each cycle:
  - Cleared if req[i]=0 or grant[i]=1.
  - Otherwise incremented, saturating at 255.
- Simultaneous events: a starvation override beats age order. A new request arriving in a LOCKED cycle is not granted that cycle and its wait_cnt still counts.
- Reset mid-operation: lock, owner and counters clear immediately and asynchronously; grant drops in the same cycle.
- A requester that raises req in the cycle after its own release re-arbitrates normally; its wait_cnt restarts from 0.

Test Plan:
- Single requester: req[0]=1, id=5, release_lock[0]=1 in the same cycle, req_wen=1, addr=0x10 -> grant=0001, mem_wen=1, mem_addr=0x10 in that cycle; lock_valid stays 0.
- Age order with wrap: ID_WIDTH=6, req[1] id=62, req[2] id=1, simultaneous -> grant=0010 (62 is older across the wrap); next cycle, with req[1] dropped, grant=0100.
- Multi-cycle lock: req[3] granted without release for 3 cycles while req[0] holds an older id -> grant stays 1000 for all 3 cycles; release in cycle 4, grant=0001 in cycle 5.
- Abort: the owner drops req while locked -> grant=0 and mem_wen=0 that cycle; the next cycle grants the oldest remaining requester.
- Starvation: MAX_WAIT=3, req[3] held with the youngest id while req[0..2] repeatedly re-request with older ids -> req[3] is granted on the cycle after wait_cnt[3] reaches 3.
- Reset: assert rst_n=0 while LOCKED with mem_wen=1 -> grant=0 and mem_wen=0 immediately; after release with req[2]=1 only, grant=0100 on the first active cycle.
